// File: rtl/keypad_tone_sequencer.sv
// Records keypad presses into a note buffer and plays them back as a square wave, one note per NOTE_CYC clocks.
// Optional macro TONE_LOOP_EN: playback repeats until clear or a second play pulse.
module keypad_tone_sequencer #(
   parameter int KEY_W    = 4,
   parameter int DEPTH    = 16,
   parameter int N_W      = 12,
   parameter int BASE_N   = 1000,
   parameter int STEP_N   = 100,
   parameter int NOTE_CYC = 12_500_000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [KEY_W-1:0]       key_pos,
   input  logic                   key_valid,
   input  logic                   play,
   input  logic                   clear,
   output logic                   tone_out,
   output logic                   playing,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic [N_W-1:0]         cur_n
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;
   localparam int T_W   = $clog2(NOTE_CYC);
   localparam logic [N_W-1:0] N_MAX = '1;

   typedef enum logic {IDLE, PLAY} state_t;

   state_t             state_q, state_d;
   logic               key_valid_d;
   logic               press, start, stop, rec_en, note_end, last_note;
   logic [KEY_W-1:0]   note_mem [DEPTH];
   logic [IDX_W-1:0]   idx;
   logic [T_W-1:0]     note_tmr;
   logic [N_W-1:0]     half_cnt, note_n;
   logic [31:0]        n_wide;

   assign press     = key_valid & ~key_valid_d;
   assign full      = (count == CNT_W'(DEPTH));
   assign playing   = (state_q == PLAY);
   assign note_end  = playing & (note_tmr == T_W'(NOTE_CYC - 1));
   assign last_note = ({1'b0, idx} == count - CNT_W'(1));
   assign start     = (state_q == IDLE) & (state_d == PLAY);
   assign stop      = playing & (state_d == IDLE);
   // A play pulse that is accepted takes precedence over a simultaneous press.
   assign rec_en    = (state_q == IDLE) & press & ~full & ~start & ~clear;

   // Tone mapping evaluated wide, then clamped into N_W bits.
   assign n_wide = 32'(BASE_N) + 32'(STEP_N) * 32'(note_mem[idx]);
   assign note_n = (n_wide > 32'(N_MAX)) ? N_MAX : n_wide[N_W-1:0];
   assign cur_n  = playing ? note_n : '0;

   // NOTE: every output of this block gets a default first so no latch can be inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (play && count != '0) state_d = PLAY;
         PLAY: begin
`ifdef TONE_LOOP_EN
            if (play) state_d = IDLE;
`else
            if (note_end && last_note) state_d = IDLE;
`endif
         end
      endcase
      if (clear) state_d = IDLE;
   end

   // NOTE: registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_valid_d <= 1'b0;
         count       <= '0;
         idx         <= '0;
         note_tmr    <= '0;
         half_cnt    <= '0;
         tone_out    <= 1'b0;
      end else begin
         key_valid_d <= key_valid;
         if (clear)       count <= '0;
         else if (rec_en) count <= count + CNT_W'(1);

         if (start) begin
            idx      <= '0;
            note_tmr <= '0;
            half_cnt <= '0;
            tone_out <= 1'b0;
         end else if (stop || !playing) begin
            tone_out <= 1'b0;
         end else if (note_end) begin
            idx      <= last_note ? '0 : idx + IDX_W'(1);
            note_tmr <= '0;
            half_cnt <= '0;
            tone_out <= 1'b0;
         end else begin
            note_tmr <= note_tmr + T_W'(1);
            if (cur_n == '0) begin
               half_cnt <= '0;
               tone_out <= 1'b0;
            end else if (half_cnt == cur_n - N_W'(1)) begin
               half_cnt <= '0;
               tone_out <= ~tone_out;
            end else begin
               half_cnt <= half_cnt + N_W'(1);
            end
         end
      end
   end

   // NOTE: the note buffer is deliberately not reset; count alone defines which entries are valid.
   always_ff @(posedge clk) begin
      if (rec_en) note_mem[count[IDX_W-1:0]] <= key_pos;
   end

endmodule

// File: tb/tb_keypad_tone_sequencer.sv
// Scoreboard bench for keypad_tone_sequencer: a short-note instance (NOTE_CYC=200) checks sequencing,
// a long-note instance (NOTE_CYC=6000) on the same inputs checks the square-wave period.
module tb_keypad_tone_sequencer;
   typedef struct {
      int n;
      int gap;
   } note_exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] key_pos = '0;
   logic       key_valid = 1'b0, play = 1'b0, clear = 1'b0;
   logic       tone_out, playing, full;
   logic [4:0] count;
   logic [11:0] cur_n;
   logic       tone_l, playing_l, full_l;
   logic [4:0] count_l;
   logic [11:0] cur_n_l;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int long_start = 0;
   bit mon_en   = 1'b0;

   note_exp_t exp_n[$];
   int        exp_cnt[$];
   int        exp_tone[$];

   keypad_tone_sequencer #(.NOTE_CYC(200)) u_dut (
      .clk(clk), .rst(rst), .key_pos(key_pos), .key_valid(key_valid), .play(play), .clear(clear),
      .tone_out(tone_out), .playing(playing), .count(count), .full(full), .cur_n(cur_n)
   );

   keypad_tone_sequencer #(.NOTE_CYC(6000)) u_long (
      .clk(clk), .rst(rst), .key_pos(key_pos), .key_valid(key_valid), .play(play), .clear(clear),
      .tone_out(tone_l), .playing(playing_l), .count(count_l), .full(full_l), .cur_n(cur_n_l)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) tick();
   endtask

   task automatic press(input int k, input int hold);
      key_pos   = 4'(k);
      key_valid = 1'b1;
      repeat (hold) tick();
      key_valid = 1'b0;
      repeat (2) tick();
   endtask

   task automatic push_n(input int n, input int gap);
      note_exp_t e;
      e.n   = n;
      e.gap = gap;
      exp_n.push_back(e);
   endtask

   // Monitor: every observed change of cur_n, count or the long tone pops one expectation.
   int   last_n = 0, last_cnt = 0, last_chg = 0;
   logic last_tone_l = 1'b0;
   always @(negedge clk) begin
      note_exp_t e;
      if (mon_en) begin
         if (int'(cur_n) != last_n) begin
            if (exp_n.size() == 0) check("cur_n unexpected change", int'(cur_n), last_n);
            else begin
               e = exp_n.pop_front();
               check("cur_n", int'(cur_n), e.n);
               if (e.gap != 0) check("note length", cyc - last_chg, e.gap);
            end
            last_n   = int'(cur_n);
            last_chg = cyc;
         end
         if (int'(count) != last_cnt) begin
            if (exp_cnt.size() == 0) check("count unexpected change", int'(count), last_cnt);
            else check("count", int'(count), exp_cnt.pop_front());
            last_cnt = int'(count);
         end
         if (tone_l !== last_tone_l) begin
            if (exp_tone.size() == 0) check("tone unexpected toggle", cyc - long_start, -1);
            else check("tone toggle time", cyc - long_start, exp_tone.pop_front());
            last_tone_l = tone_l;
         end
         if (tone_out !== 1'b0) check("short-note tone stays low", int'(tone_out), 0);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int s;
      int seq[4] = '{1300, 1000, 2500, 1700};

      // Reset state
      repeat (3) tick();
      check("reset tone_out", int'(tone_out), 0);
      check("reset playing", int'(playing), 0);
      check("reset count", int'(count), 0);
      check("reset cur_n", int'(cur_n), 0);
      check("reset full", int'(full), 0);
      rst = 1'b1;
      tick();
      mon_en = 1'b1;

      // Record 3, 0, 15, then a long hold of 7 counts once
      for (int i = 1; i <= 4; i++) exp_cnt.push_back(i);
      press(3, 5);
      press(0, 5);
      press(15, 5);
      check("count after three presses", int'(count), 3);
      press(7, 50);
      check("count after long hold", int'(count), 4);

      // Playback
      long_start = 0;
`ifdef TONE_LOOP_EN
      push_n(seq[0], 0);
      for (int k = 1; k <= 30; k++) push_n(seq[k % 4], 200);
      push_n(0, 101);
`else
      push_n(1300, 0);
      push_n(1000, 200);
      push_n(2500, 200);
      push_n(1700, 200);
      push_n(0, 200);
`endif
      for (int k = 1; k <= 4; k++) exp_tone.push_back(1300 * k);
      play = 1'b1;
      tick();
      play = 1'b0;
      s = cyc;
      long_start = s;
      check("playing after play", int'(playing), 1);
      check("first note cur_n", int'(cur_n), 1300);
      check("long first note cur_n", int'(cur_n_l), 1300);
      wait_until(s + 900);
`ifdef TONE_LOOP_EN
      check("still playing in loop", int'(playing), 1);
`else
      check("idle after last note", int'(playing), 0);
      check("cur_n after last note", int'(cur_n), 0);
`endif
      wait_until(s + 6050);
      check("long second note cur_n", int'(cur_n_l), 1000);
      wait_until(s + 6100);
      exp_cnt.push_back(0);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("tone toggles all seen", exp_tone.size(), 0);
      check("playing after clear", int'(playing), 0);

      // Play with empty buffer is ignored; fill to 16 and drop the 17th
      play = 1'b1;
      tick();
      play = 1'b0;
      check("play with count 0 ignored", int'(playing), 0);
      for (int i = 1; i <= 16; i++) exp_cnt.push_back(i);
      for (int i = 0; i <= 16; i++) press(i % 16, 2);
      check("count when full", int'(count), 16);
      check("full flag", int'(full), 1);

      // Clear during the second note
      push_n(1000, 0);
      push_n(1100, 200);
      push_n(0, 51);
      exp_cnt.push_back(0);
      play = 1'b1;
      tick();
      play = 1'b0;
      s = cyc;
      wait_until(s + 250);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("playing after mid clear", int'(playing), 0);
      check("tone after mid clear", int'(tone_out), 0);
      check("count after mid clear", int'(count), 0);
      check("full after mid clear", int'(full), 0);

      // Press and play in the same cycle: play wins
      exp_cnt.push_back(1);
      exp_cnt.push_back(2);
      press(2, 3);
      press(9, 3);
      push_n(1200, 0);
`ifdef TONE_LOOP_EN
      for (int k = 1; k < 6; k++) push_n((k % 2) ? 1900 : 1200, 200);
      push_n(0, 200);
`else
      push_n(1900, 200);
      push_n(0, 200);
`endif
      key_pos   = 4'd4;
      key_valid = 1'b1;
      play      = 1'b1;
      tick();
      play      = 1'b0;
      s = cyc;
      check("playing after press+play", int'(playing), 1);
      check("count after press+play", int'(count), 2);
      tick();
      key_valid = 1'b0;
`ifdef TONE_LOOP_EN
      wait_until(s + 1199);
      play = 1'b1;
      tick();
      play = 1'b0;
`else
      wait_until(s + 100);
      play = 1'b1;
      tick();
      play = 1'b0;
      check("play ignored while playing", int'(playing), 1);
      wait_until(s + 450);
`endif
      check("stopped after sequence", int'(playing), 0);
      check("buffer kept", int'(count), 2);

      // Asynchronous reset mid-playback
      push_n(1200, 0);
      play = 1'b1;
      tick();
      play = 1'b0;
      s = cyc;
      wait_until(s + 100);
      push_n(0, 0);
      exp_cnt.push_back(0);
      #2;
      rst = 1'b0;
      #1;
      check("async reset tone_out", int'(tone_out), 0);
      check("async reset playing", int'(playing), 0);
      check("async reset count", int'(count), 0);
      check("async reset cur_n", int'(cur_n), 0);
      check("async reset long playing", int'(playing_l), 0);
      repeat (2) tick();
      rst = 1'b1;
      repeat (3) tick();

      check("cur_n expectations drained", exp_n.size(), 0);
      check("count expectations drained", exp_cnt.size(), 0);
      check("tone expectations drained", exp_tone.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
